// File: rtl/piso_serializer.sv
// Parallel-in / serial-out frame serializer.
// Accepts a WIDTH-bit word on load & ready and shifts it out one bit per clock,
// flagging the first (sof) and last (eof) bit of each frame, with an optional
// trailing parity bit. A word offered during the eof cycle chains into the next
// frame with no idle cycle.
module piso_serializer #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] pdata,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int unsigned FrameLen = WIDTH + (PARITY_EN ? 1 : 0);
    localparam int unsigned CntW     = $clog2(FrameLen);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e             state_q, state_d;
    // Holds the bits still to be sent, aligned so the next bit sits at the
    // transmit end (MSB for MSB_FIRST, LSB otherwise).
    logic [WIDTH-1:0]   shift_q, shift_d;
    // Number of frame bits remaining after the one currently on sout.
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               parity_q, parity_d;
    logic               sout_q, sout_d;
    logic               valid_q, valid_d;
    logic               sof_q, sof_d;
    logic               eof_q, eof_d;
    logic               accept;

    // Ready depends only on registered state, never on load.
    always_comb begin
        ready  = (state_q == StIdle) | ((state_q == StShift) & eof_q);
        accept = load & ready;
    end

    // Next-state and output-register logic for the IDLE/SHIFT frame machine.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        sout_d   = sout_q;
        valid_d  = valid_q;
        sof_d    = sof_q;
        eof_d    = eof_q;

        if (accept) begin
            state_d  = StShift;
            parity_d = (^pdata) ^ PARITY_ODD;
            cnt_d    = CntW'(FrameLen - 1);
            valid_d  = 1'b1;
            sof_d    = 1'b1;
            eof_d    = (FrameLen == 1);
            // First bit goes straight to sout; the remainder is pre-shifted.
            if (MSB_FIRST) begin
                sout_d  = pdata[WIDTH-1];
                shift_d = {pdata[WIDTH-2:0], 1'b0};
            end else begin
                sout_d  = pdata[0];
                shift_d = {1'b0, pdata[WIDTH-1:1]};
            end
        end else if (state_q == StShift) begin
            if (eof_q) begin
                state_d = StIdle;
                shift_d = '0;
                cnt_d   = '0;
                sout_d  = 1'b0;
                valid_d = 1'b0;
                sof_d   = 1'b0;
                eof_d   = 1'b0;
            end else begin
                cnt_d = cnt_q - CntW'(1);
                sof_d = 1'b0;
                eof_d = (cnt_q == CntW'(1));
                if (PARITY_EN && (cnt_q == CntW'(1))) begin
                    sout_d = parity_q;
                end else if (MSB_FIRST) begin
                    sout_d  = shift_q[WIDTH-1];
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                end else begin
                    sout_d  = shift_q[0];
                    shift_d = {1'b0, shift_q[WIDTH-1:1]};
                end
            end
        end
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            sout_q   <= 1'b0;
            valid_q  <= 1'b0;
            sof_q    <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
            sout_q   <= sout_d;
            valid_q  <= valid_d;
            sof_q    <= sof_d;
            eof_q    <= eof_d;
        end
    end

    // Registered outputs; busy mirrors sout_valid.
    always_comb begin
        sout       = sout_q;
        sout_valid = valid_q;
        sof        = sof_q;
        eof        = eof_q;
        busy       = valid_q;
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed testbench for piso_serializer. Four instances cover the parameter
// variants: 0 = MSB-first no parity, 1 = even parity, 2 = odd parity,
// 3 = LSB-first no parity. Outputs are sampled on the falling edge and
// compared as {sout, sout_valid, sof, eof, ready, busy}.
module tb_piso_serializer;

    logic       clk;
    logic       reset;
    logic [3:0] load;
    logic [7:0] pdata [4];
    logic [3:0] ready;
    logic [3:0] sout;
    logic [3:0] sout_valid;
    logic [3:0] sof;
    logic [3:0] eof;
    logic [3:0] busy;

    int n_checks;
    int n_fail;

    localparam logic [5:0] IdleObs = 6'b000010;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_msb (
        .clk(clk), .reset(reset), .load(load[0]), .pdata(pdata[0]), .ready(ready[0]),
        .sout(sout[0]), .sout_valid(sout_valid[0]), .sof(sof[0]), .eof(eof[0]), .busy(busy[0])
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_par_even (
        .clk(clk), .reset(reset), .load(load[1]), .pdata(pdata[1]), .ready(ready[1]),
        .sout(sout[1]), .sout_valid(sout_valid[1]), .sof(sof[1]), .eof(eof[1]), .busy(busy[1])
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_par_odd (
        .clk(clk), .reset(reset), .load(load[2]), .pdata(pdata[2]), .ready(ready[2]),
        .sout(sout[2]), .sout_valid(sout_valid[2]), .sof(sof[2]), .eof(eof[2]), .busy(busy[2])
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .load(load[3]), .pdata(pdata[3]), .ready(ready[3]),
        .sout(sout[3]), .sout_valid(sout_valid[3]), .sof(sof[3]), .eof(eof[3]), .busy(busy[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] get_obs(input int d);
        return {sout[d], sout_valid[d], sof[d], eof[d], ready[d], busy[d]};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        load  = '0;
        for (int d = 0; d < 4; d++) pdata[d] = 8'h00;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (get_obs(d) !== IdleObs) begin
                n_fail++;
                $display("FAIL reset dut%0d: got %b expected %b", d, get_obs(d), IdleObs);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] word;
        logic [5:0] exp;
        word = 8'hAA;
        @(negedge clk);
        load[0]  = 1'b1;
        pdata[0] = word;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) load[0] = 1'b0;
            exp = {word[7-i], 1'b1, i == 0, i == 7, i == 7, 1'b1};
            n_checks++;
            if (get_obs(0) !== exp) begin
                n_fail++;
                $display("FAIL basic bit %0d: got %b expected %b", i + 1, get_obs(0), exp);
            end
        end
        @(negedge clk);
        n_checks++;
        if (get_obs(0) !== IdleObs) begin
            n_fail++;
            $display("FAIL basic idle: got %b expected %b", get_obs(0), IdleObs);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        logic [5:0]  exp;
        stream = {8'hAA, 8'hCC};
        @(negedge clk);
        load[0]  = 1'b1;
        pdata[0] = 8'hAA;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) pdata[0] = 8'hCC;
            if (i == 8) load[0] = 1'b0;
            exp = {stream[15-i], 1'b1, (i == 0) || (i == 8), (i == 7) || (i == 15),
                   (i == 7) || (i == 15), 1'b1};
            n_checks++;
            if (get_obs(0) !== exp) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %b expected %b", i + 1, get_obs(0), exp);
            end
        end
        @(negedge clk);
        n_checks++;
        if (get_obs(0) !== IdleObs) begin
            n_fail++;
            $display("FAIL back_to_back idle: got %b expected %b", get_obs(0), IdleObs);
        end
    endtask

    task automatic test_parity();
        int         dut  [3];
        logic [7:0] word [3];
        logic [8:0] bits [3];
        logic [8:0] cur;
        logic [5:0] exp;
        dut[0] = 1; word[0] = 8'hCC; bits[0] = 9'b11001100_0;
        dut[1] = 1; word[1] = 8'hA8; bits[1] = 9'b10101000_1;
        dut[2] = 2; word[2] = 8'hCC; bits[2] = 9'b11001100_1;
        for (int c = 0; c < 3; c++) begin
            cur = bits[c];
            @(negedge clk);
            load[dut[c]]  = 1'b1;
            pdata[dut[c]] = word[c];
            for (int i = 0; i < 9; i++) begin
                @(negedge clk);
                if (i == 0) load[dut[c]] = 1'b0;
                exp = {cur[8-i], 1'b1, i == 0, i == 8, i == 8, 1'b1};
                n_checks++;
                if (get_obs(dut[c]) !== exp) begin
                    n_fail++;
                    $display("FAIL parity case %0d bit %0d: got %b expected %b",
                             c, i + 1, get_obs(dut[c]), exp);
                end
            end
            @(negedge clk);
            n_checks++;
            if (get_obs(dut[c]) !== IdleObs) begin
                n_fail++;
                $display("FAIL parity case %0d idle: got %b expected %b", c, get_obs(dut[c]), IdleObs);
            end
        end
    endtask

    task automatic test_lsb_ignored_load();
        logic [5:0] exp;
        @(negedge clk);
        load[3]  = 1'b1;
        pdata[3] = 8'h01;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp = {i == 0, 1'b1, i == 0, i == 7, i == 7, 1'b1};
            n_checks++;
            if (get_obs(3) !== exp) begin
                n_fail++;
                $display("FAIL lsb_ignored bit %0d: got %b expected %b", i + 1, get_obs(3), exp);
            end
            // Offer 0xFF while busy (bits 2..7); it must be ignored.
            if (i >= 1 && i <= 6) begin
                load[3]  = 1'b1;
                pdata[3] = 8'hFF;
            end else begin
                load[3]  = 1'b0;
                pdata[3] = 8'h00;
            end
        end
        @(negedge clk);
        n_checks++;
        if (get_obs(3) !== IdleObs) begin
            n_fail++;
            $display("FAIL lsb_ignored idle: got %b expected %b", get_obs(3), IdleObs);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] word;
        logic [5:0] exp;
        word = 8'hAA;
        @(negedge clk);
        load[0]  = 1'b1;
        pdata[0] = word;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) load[0] = 1'b0;
            exp = {word[7-i], 1'b1, i == 0, 1'b0, 1'b0, 1'b1};
            n_checks++;
            if (get_obs(0) !== exp) begin
                n_fail++;
                $display("FAIL reset_mid bit %0d: got %b expected %b", i + 1, get_obs(0), exp);
            end
        end
        // Assert reset between edges; outputs must clear without a clock edge.
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (get_obs(0) !== IdleObs) begin
            n_fail++;
            $display("FAIL reset_mid async clear: got %b expected %b", get_obs(0), IdleObs);
        end
        @(negedge clk);
        reset    = 1'b0;
        load[0]  = 1'b1;
        pdata[0] = 8'h0F;
        word     = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) load[0] = 1'b0;
            exp = {word[7-i], 1'b1, i == 0, i == 7, i == 7, 1'b1};
            n_checks++;
            if (get_obs(0) !== exp) begin
                n_fail++;
                $display("FAIL reset_mid refill bit %0d: got %b expected %b", i + 1, get_obs(0), exp);
            end
        end
        @(negedge clk);
        n_checks++;
        if (get_obs(0) !== IdleObs) begin
            n_fail++;
            $display("FAIL reset_mid idle: got %b expected %b", get_obs(0), IdleObs);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_parity();
        test_lsb_ignored_load();
        test_reset_mid_frame();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
